// File: rtl/mmio_timer_responder.sv
// -----------------------------------------------------------------------------
// mmio_timer_responder
//
// Memory-mapped countdown timer plus a 16-bit LED register. It sits on the CPU
// data port next to DMEM and uses the same load/store handshake. It decodes a
// 32-byte window at BASE. Loads are answered combinationally. Stores, the
// prescaler and the countdown all update on the rising edge of clk_in.
//
// Register map (word index = dm_addr[4:2]):
//   0 CTRL   : bit0 en, bit1 reload, bit2 ie
//   1 LOAD   : reload value; writing it also loads COUNT
//   2 COUNT  : current count, read-only
//   3 STATUS : bit0 expired, write-1-to-clear
//   4 LED    : bits [15:0]
//   5-7      : reserved, read 0, writes ignored
//
// Ports:
//   clk_in, reset           : rising-edge clock, async active-high reset
//   dm_ena, dm_r, dm_w      : access valid, read strobe, write strobe
//   sb/sh/sw_flag           : store size (one-hot with dm_w)
//   lb/lh/lbu/lhu/lw_flag   : load size and signedness (one-hot with dm_r)
//   dm_addr, dm_data_w      : raw byte address, store data (low-aligned)
//   hit                     : access falls inside this block's window
//   rd_data                 : extended load result, 0 when not reading here
//   irq                     : expired AND ie
//   led                     : LED register contents
// -----------------------------------------------------------------------------
module mmio_timer_responder #(
    parameter logic [31:0] BASE     = 32'h10010400,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        dm_ena,
    input  logic        dm_r,
    input  logic        dm_w,
    input  logic        sb_flag,
    input  logic        sh_flag,
    input  logic        sw_flag,
    input  logic        lb_flag,
    input  logic        lh_flag,
    input  logic        lbu_flag,
    input  logic        lhu_flag,
    input  logic        lw_flag,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_data_w,
    output logic        hit,
    output logic [31:0] rd_data,
    output logic        irq,
    output logic [15:0] led
);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_LOAD   = 3'd1,
        REG_COUNT  = 3'd2,
        REG_STATUS = 3'd3,
        REG_LED    = 3'd4
    } reg_sel_e;

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    // Architectural state
    logic        ctrl_en;
    logic        ctrl_reload;
    logic        ctrl_ie;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic        expired_q;
    logic [15:0] led_q;
    logic [15:0] presc_q;

    // Decode
    logic [2:0]  reg_sel;
    logic        wr_en;
    logic        rd_en;

    assign hit     = dm_ena && (dm_addr[31:5] == BASE[31:5]);
    assign reg_sel = dm_addr[4:2];
    assign wr_en   = hit && dm_w;
    assign rd_en   = hit && dm_r;

    // Byte-lane steering: replicate the narrow store data into every lane so
    // the lane mask alone decides which bytes land in the target register.
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;
    logic [31:0] bit_mask;

    // NOTE: every signal driven in always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        lane_mask = 4'b0000;
        lane_data = dm_data_w;
        if (sw_flag) begin
            lane_mask = 4'b1111;
        end else if (sh_flag) begin
            lane_mask = dm_addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{dm_data_w[15:0]}};
        end else if (sb_flag) begin
            lane_mask = 4'b0001 << dm_addr[1:0];
            lane_data = {4{dm_data_w[7:0]}};
        end
    end

    assign bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}},
                       {8{lane_mask[1]}}, {8{lane_mask[0]}}};

    // A store with no size flag touches nothing, so a LOAD side effect can
    // never fire on an empty write.
    logic wr_any;
    logic wr_ctrl;
    logic wr_load;
    logic wr_led;
    logic status_clear;

    assign wr_any       = wr_en && (lane_mask != 4'b0000);
    assign wr_ctrl      = wr_any && (reg_sel == REG_CTRL);
    assign wr_load      = wr_any && (reg_sel == REG_LOAD);
    assign wr_led       = wr_any && (reg_sel == REG_LED);
    assign status_clear = wr_any && (reg_sel == REG_STATUS)
                          && lane_mask[0] && lane_data[0];

    // Merged values: bytes outside the lane mask keep their old contents.
    logic [2:0]  ctrl_next;
    logic [31:0] load_next;
    logic [15:0] led_next;

    assign ctrl_next = ({ctrl_ie, ctrl_reload, ctrl_en} & ~bit_mask[2:0])
                       | (lane_data[2:0] & bit_mask[2:0]);
    assign load_next = (load_q & ~bit_mask) | (lane_data & bit_mask);
    assign led_next  = (led_q & ~bit_mask[15:0]) | (lane_data[15:0] & bit_mask[15:0]);

    // Timer events
    logic tick;
    logic expire_now;

    assign tick       = ctrl_en && (presc_q == PRESC_LAST);
    assign expire_now = tick && (count_q == 32'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            presc_q <= 16'd0;
        end else if (ctrl_en) begin
            presc_q <= (presc_q == PRESC_LAST) ? 16'd0 : presc_q + 16'd1;
        end else begin
            presc_q <= 16'd0;
        end
    end

    // A CPU write to CTRL takes priority over the one-shot auto-clear of en.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            ctrl_en     <= 1'b0;
            ctrl_reload <= 1'b0;
            ctrl_ie     <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en     <= ctrl_next[0];
            ctrl_reload <= ctrl_next[1];
            ctrl_ie     <= ctrl_next[2];
        end else if (expire_now && !ctrl_reload) begin
            ctrl_en <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            load_q <= 32'd0;
        end else if (wr_load) begin
            load_q <= load_next;
        end
    end

    // A write to LOAD overrides the tick update of COUNT on the same edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count_q <= 32'd0;
        end else if (wr_load) begin
            count_q <= load_next;
        end else if (tick) begin
            if (count_q != 32'd0) begin
                count_q <= count_q - 32'd1;
            end else if (ctrl_reload) begin
                count_q <= load_q;
            end
        end
    end

    // Setting by expiry wins over a write-1-to-clear on the same edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            expired_q <= 1'b0;
        end else if (expire_now) begin
            expired_q <= 1'b1;
        end else if (status_clear) begin
            expired_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            led_q <= 16'd0;
        end else if (wr_led) begin
            led_q <= led_next;
        end
    end

    // Read path
    logic [31:0] reg_word;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;

    always_comb begin
        reg_word = 32'd0;
        case (reg_sel)
            REG_CTRL:   reg_word = {29'd0, ctrl_ie, ctrl_reload, ctrl_en};
            REG_LOAD:   reg_word = load_q;
            REG_COUNT:  reg_word = count_q;
            REG_STATUS: reg_word = {31'd0, expired_q};
            REG_LED:    reg_word = {16'd0, led_q};
            default:    reg_word = 32'd0;
        endcase
    end

    assign rd_half = dm_addr[1] ? reg_word[31:16] : reg_word[15:0];
    assign rd_byte = reg_word[{dm_addr[1:0], 3'b000} +: 8];

    always_comb begin
        rd_data = 32'd0;
        if (rd_en) begin
            if (lw_flag) begin
                rd_data = reg_word;
            end else if (lh_flag || lhu_flag) begin
                rd_data = {{16{lh_flag & rd_half[15]}}, rd_half};
            end else if (lb_flag || lbu_flag) begin
                rd_data = {{24{lb_flag & rd_byte[7]}}, rd_byte};
            end
        end
    end

    assign irq = expired_q && ctrl_ie;
    assign led = led_q;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// -----------------------------------------------------------------------------
// Testbench for mmio_timer_responder. Two instances share one bus: one with
// PRESCALE = 1 and one with PRESCALE = 4. Directed sequences cover reset,
// one-shot, auto-reload and a table of decode/byte-lane vectors; a random
// phase compares both instances against a behavioural model every cycle.
// -----------------------------------------------------------------------------
module tb_mmio_timer_responder;

    localparam logic [31:0] BASE = 32'h10010400;

    typedef enum logic [3:0] {
        OP_IDLE, OP_SB, OP_SH, OP_SW, OP_LB, OP_LH, OP_LBU, OP_LHU, OP_LW
    } op_e;

    typedef struct packed {
        logic        en;
        logic        reload;
        logic        ie;
        logic        expired;
        logic [31:0] load;
        logic [31:0] count;
        logic [15:0] led;
        logic [15:0] presc;
    } model_t;

    typedef struct {
        op_e         op;
        logic        ena;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_hit;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        dm_ena = 1'b0, dm_r = 1'b0, dm_w = 1'b0;
    logic        sb_flag = 1'b0, sh_flag = 1'b0, sw_flag = 1'b0;
    logic        lb_flag = 1'b0, lh_flag = 1'b0, lbu_flag = 1'b0;
    logic        lhu_flag = 1'b0, lw_flag = 1'b0;
    logic [31:0] dm_addr = 32'd0, dm_data_w = 32'd0;

    logic        hit1, irq1, hit4, irq4;
    logic [31:0] rd1, rd4;
    logic [15:0] led1, led4;

    op_e         cur_op   = OP_IDLE;
    logic        cur_ena  = 1'b0;
    logic [31:0] cur_addr = 32'd0;
    logic [31:0] cur_data = 32'd0;

    model_t m1, m4;
    int vectors    = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    mmio_timer_responder #(.BASE(BASE), .PRESCALE(1)) dut1 (
        .clk_in(clk_in), .reset(reset), .dm_ena(dm_ena), .dm_r(dm_r), .dm_w(dm_w),
        .sb_flag(sb_flag), .sh_flag(sh_flag), .sw_flag(sw_flag),
        .lb_flag(lb_flag), .lh_flag(lh_flag), .lbu_flag(lbu_flag),
        .lhu_flag(lhu_flag), .lw_flag(lw_flag),
        .dm_addr(dm_addr), .dm_data_w(dm_data_w),
        .hit(hit1), .rd_data(rd1), .irq(irq1), .led(led1)
    );

    mmio_timer_responder #(.BASE(BASE), .PRESCALE(4)) dut4 (
        .clk_in(clk_in), .reset(reset), .dm_ena(dm_ena), .dm_r(dm_r), .dm_w(dm_w),
        .sb_flag(sb_flag), .sh_flag(sh_flag), .sw_flag(sw_flag),
        .lb_flag(lb_flag), .lh_flag(lh_flag), .lbu_flag(lbu_flag),
        .lhu_flag(lhu_flag), .lw_flag(lw_flag),
        .dm_addr(dm_addr), .dm_data_w(dm_data_w),
        .hit(hit4), .rd_data(rd4), .irq(irq4), .led(led4)
    );

    // ---------------------------------------------------------------- model
    function automatic bit is_store(input op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic bit is_load(input op_e op);
        return op inside {OP_LB, OP_LH, OP_LBU, OP_LHU, OP_LW};
    endfunction

    function automatic int op_bytes(input op_e op);
        if (op inside {OP_SB, OP_LB, OP_LBU}) return 1;
        if (op inside {OP_SH, OP_LH, OP_LHU}) return 2;
        return 4;
    endfunction

    function automatic bit model_hit(input logic ena, input logic [31:0] addr);
        return ena && (addr >= BASE) && (addr - BASE < 32'd32);
    endfunction

    function automatic logic [31:0] model_word(input model_t m, input logic [2:0] idx);
        case (idx)
            3'd0:    return {29'd0, m.ie, m.reload, m.en};
            3'd1:    return m.load;
            3'd2:    return m.count;
            3'd3:    return {31'd0, m.expired};
            3'd4:    return {16'd0, m.led};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input model_t m, input op_e op,
                                               input logic ena, input logic [31:0] addr);
        logic [31:0] w, v, lim;
        int nb, lo;
        if (!model_hit(ena, addr) || !is_load(op)) return 32'd0;
        w  = model_word(m, addr[4:2]);
        nb = op_bytes(op);
        if (nb == 4) return w;
        lo  = (int'(addr[1:0]) / nb) * nb;
        lim = 32'd1 << (8 * nb);
        v   = (w >> (8 * lo)) & (lim - 32'd1);
        if ((op == OP_LB || op == OP_LH) && v[8 * nb - 1]) v = v | ~(lim - 32'd1);
        return v;
    endfunction

    function automatic model_t model_step(input model_t m, input int prescale, input op_e op,
                                          input logic ena, input logic [31:0] addr,
                                          input logic [31:0] data);
        model_t n = m;
        logic tick, expiring;
        logic [31:0] w;
        int nb, lo;
        tick     = m.en && (int'(m.presc) == prescale - 1);
        expiring = tick && (m.count == 32'd0);
        n.presc  = m.en ? 16'((int'(m.presc) + 1) % prescale) : 16'd0;
        if (tick) begin
            if (m.count != 32'd0) begin
                n.count = m.count - 32'd1;
            end else begin
                n.expired = 1'b1;
                if (m.reload) n.count = m.load;
                else          n.en    = 1'b0;
            end
        end
        if (model_hit(ena, addr) && is_store(op)) begin
            nb = op_bytes(op);
            lo = (int'(addr[1:0]) / nb) * nb;
            w  = model_word(m, addr[4:2]);
            for (int i = 0; i < nb; i++) w[(lo + i) * 8 +: 8] = data[i * 8 +: 8];
            case (addr[4:2])
                3'd0: begin n.en = w[0]; n.reload = w[1]; n.ie = w[2]; end
                3'd1: begin n.load = w; n.count = w; end
                3'd3: if (lo == 0 && w[0] && !expiring) n.expired = 1'b0;
                3'd4: n.led = w[15:0];
                default: ;
            endcase
        end
        return n;
    endfunction

    // ---------------------------------------------------------------- tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_bus(input op_e op, input logic [31:0] addr,
                           input logic [31:0] data, input logic ena);
        cur_op = op; cur_addr = addr; cur_data = data; cur_ena = ena;
        dm_ena    = ena;
        dm_w      = is_store(op);
        dm_r      = is_load(op);
        sb_flag   = (op == OP_SB);
        sh_flag   = (op == OP_SH);
        sw_flag   = (op == OP_SW);
        lb_flag   = (op == OP_LB);
        lh_flag   = (op == OP_LH);
        lbu_flag  = (op == OP_LBU);
        lhu_flag  = (op == OP_LHU);
        lw_flag   = (op == OP_LW);
        dm_addr   = addr;
        dm_data_w = data;
        #1;
    endtask

    task automatic step();
        @(posedge clk_in);
        if (!reset) begin
            m1 = model_step(m1, 1, cur_op, cur_ena, cur_addr, cur_data);
            m4 = model_step(m4, 4, cur_op, cur_ena, cur_addr, cur_data);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_bus(OP_IDLE, 32'd0, 32'd0, 1'b0);
        m1 = '0;
        m4 = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        #1;
    endtask

    function automatic vec_t mk(input op_e op, input logic [31:0] addr, input logic [31:0] data,
                                input logic ena, input logic exp_hit,
                                input logic [31:0] exp_rd, input logic [15:0] exp_led);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.ena = ena;
        v.exp_hit = exp_hit; v.exp_rd = exp_rd; v.exp_led = exp_led;
        return v;
    endfunction

    // ---------------------------------------------------------------- test
    initial begin
        vec_t tbl[$];
        logic [31:0] exp_status;

        // Reset state
        do_reset();
        check("rst_irq1", {31'd0, irq1}, 32'd0);
        check("rst_led1", {16'd0, led1}, 32'd0);
        check("rst_irq4", {31'd0, irq4}, 32'd0);
        check("rst_led4", {16'd0, led4}, 32'd0);
        set_bus(OP_LW, BASE + 32'h0, 32'd0, 1'b1);
        check("rst_ctrl", rd1, 32'd0);
        check("rst_hit", {31'd0, hit1}, 32'd1);

        // Reset in mid-count
        set_bus(OP_SW, BASE + 32'h10, 32'h1234, 1'b1); step();
        set_bus(OP_SW, BASE + 32'h04, 32'd100, 1'b1);  step();
        set_bus(OP_SW, BASE + 32'h00, 32'h5, 1'b1);    step();
        set_bus(OP_LW, BASE + 32'h08, 32'd0, 1'b1);
        repeat (7) step();
        check("mid_count", rd1, 32'd93);
        check("mid_led", {16'd0, led1}, 32'h1234);
        #2 reset = 1'b1;
        #1;
        m1 = '0; m4 = '0;
        check("mid_rst_count", rd1, 32'd0);
        check("mid_rst_led", {16'd0, led1}, 32'd0);
        check("mid_rst_irq", {31'd0, irq1}, 32'd0);
        set_bus(OP_LW, BASE + 32'h0C, 32'd0, 1'b1);
        check("mid_rst_status", rd1, 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        set_bus(OP_LW, BASE + 32'h08, 32'd0, 1'b1);
        step(); step();
        check("post_rst_count", rd1, 32'd0);
        check("post_rst_led", {16'd0, led1}, 32'd0);
        set_bus(OP_LW, BASE + 32'h00, 32'd0, 1'b1);
        check("post_rst_ctrl", rd1, 32'd0);

        // One-shot, PRESCALE = 1
        do_reset();
        set_bus(OP_SW, BASE + 32'h04, 32'd5, 1'b1); step();
        set_bus(OP_SW, BASE + 32'h00, 32'h5, 1'b1); step();   // edge 0
        set_bus(OP_LW, BASE + 32'h08, 32'd0, 1'b1);
        check("os_count_e0", rd1, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("os_count_e%0d", k), rd1, 32'(5 - k));
            check($sformatf("os_irq_e%0d", k), {31'd0, irq1}, 32'd0);
        end
        step();                                                // edge 6
        check("os_irq_e6", {31'd0, irq1}, 32'd1);
        set_bus(OP_LW, BASE + 32'h0C, 32'd0, 1'b1);
        check("os_status_e6", rd1, 32'd1);
        set_bus(OP_LW, BASE + 32'h00, 32'd0, 1'b1);
        check("os_ctrl_e6", rd1, 32'h4);
        set_bus(OP_LW, BASE + 32'h08, 32'd0, 1'b1);
        step();
        check("os_count_hold", rd1, 32'd0);
        check("os_irq_hold", {31'd0, irq1}, 32'd1);
        set_bus(OP_SW, BASE + 32'h0C, 32'd1, 1'b1); step();
        check("os_irq_cleared", {31'd0, irq1}, 32'd0);

        // Auto-reload, PRESCALE = 4: expiry at edges 12 and 24
        do_reset();
        set_bus(OP_SW, BASE + 32'h04, 32'd2, 1'b1); step();
        set_bus(OP_SW, BASE + 32'h00, 32'h3, 1'b1); step();   // edge 0
        for (int e = 1; e <= 24; e++) begin
            if (e == 13 || e == 24) set_bus(OP_SW, BASE + 32'h0C, 32'd1, 1'b1);
            else                    set_bus(OP_LW, BASE + 32'h0C, 32'd0, 1'b1);
            step();
            set_bus(OP_LW, BASE + 32'h0C, 32'd0, 1'b1);
            exp_status = (e == 12 || e == 24) ? 32'd1 : 32'd0;
            check($sformatf("ar_status_e%0d", e), rd4, exp_status);
        end
        check("ar_irq_no_ie", {31'd0, irq4}, 32'd0);

        // Table-driven byte lanes, LOAD halfword and decode
        do_reset();
        tbl.push_back(mk(OP_SW,  BASE + 32'h10, 32'h0,        1'b1, 1'b1, 32'h0,        16'h0000));
        tbl.push_back(mk(OP_SB,  BASE + 32'h11, 32'hAB,       1'b1, 1'b1, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_SH,  BASE + 32'h12, 32'h1234,     1'b1, 1'b1, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_LW,  BASE + 32'h10, 32'h0,        1'b1, 1'b1, 32'h0000AB00, 16'hAB00));
        tbl.push_back(mk(OP_LB,  BASE + 32'h11, 32'h0,        1'b1, 1'b1, 32'hFFFFFFAB, 16'hAB00));
        tbl.push_back(mk(OP_LBU, BASE + 32'h11, 32'h0,        1'b1, 1'b1, 32'h000000AB, 16'hAB00));
        tbl.push_back(mk(OP_LH,  BASE + 32'h10, 32'h0,        1'b1, 1'b1, 32'hFFFFAB00, 16'hAB00));
        tbl.push_back(mk(OP_LHU, BASE + 32'h12, 32'h0,        1'b1, 1'b1, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_SH,  BASE + 32'h06, 32'h8001,     1'b1, 1'b1, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_LW,  BASE + 32'h04, 32'h0,        1'b1, 1'b1, 32'h80010000, 16'hAB00));
        tbl.push_back(mk(OP_LW,  BASE + 32'h08, 32'h0,        1'b1, 1'b1, 32'h80010000, 16'hAB00));
        tbl.push_back(mk(OP_LH,  BASE + 32'h06, 32'h0,        1'b1, 1'b1, 32'hFFFF8001, 16'hAB00));
        tbl.push_back(mk(OP_LHU, BASE + 32'h06, 32'h0,        1'b1, 1'b1, 32'h00008001, 16'hAB00));
        tbl.push_back(mk(OP_LB,  BASE + 32'h07, 32'h0,        1'b1, 1'b1, 32'hFFFFFF80, 16'hAB00));
        tbl.push_back(mk(OP_SW,  BASE + 32'h08, 32'h12345678, 1'b1, 1'b1, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_LW,  BASE + 32'h08, 32'h0,        1'b1, 1'b1, 32'h80010000, 16'hAB00));
        tbl.push_back(mk(OP_SW,  BASE - 32'h4,  32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_LW,  BASE - 32'h4,  32'h0,        1'b1, 1'b0, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_SW,  BASE + 32'h30, 32'hFFFF,     1'b1, 1'b0, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_SW,  BASE + 32'h20, 32'hFFFF,     1'b1, 1'b0, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_LW,  BASE + 32'h20, 32'h0,        1'b1, 1'b0, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_SW,  BASE + 32'h10, 32'h5555,     1'b0, 1'b0, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_LW,  BASE + 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_SW,  BASE + 32'h18, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_LW,  BASE + 32'h18, 32'h0,        1'b1, 1'b1, 32'h0,        16'hAB00));
        tbl.push_back(mk(OP_LW,  BASE + 32'h10, 32'h0,        1'b1, 1'b1, 32'h0000AB00, 16'hAB00));
        tbl.push_back(mk(OP_SB,  BASE + 32'h10, 32'h01,       1'b1, 1'b1, 32'h0,        16'hAB01));
        tbl.push_back(mk(OP_LHU, BASE + 32'h11, 32'h0,        1'b1, 1'b1, 32'h0000AB01, 16'hAB01));
        tbl.push_back(mk(OP_LW,  BASE + 32'h00, 32'h0,        1'b1, 1'b1, 32'h0,        16'hAB01));
        tbl.push_back(mk(OP_LW,  BASE + 32'h0C, 32'h0,        1'b1, 1'b1, 32'h0,        16'hAB01));
        for (int i = 0; i < tbl.size(); i++) begin
            set_bus(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].ena);
            check($sformatf("vec%0d_hit", i), {31'd0, hit1}, {31'd0, tbl[i].exp_hit});
            check($sformatf("vec%0d_rd", i), rd1, tbl[i].exp_rd);
            step();
            check($sformatf("vec%0d_led", i), {16'd0, led1}, {16'd0, tbl[i].exp_led});
        end

        // Randomized traffic against the model, both prescale settings
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            op_e         op;
            logic [31:0] addr, data;
            logic        ena;
            int          r;
            op   = op_e'($urandom_range(0, 8));
            ena  = ($urandom_range(0, 7) != 0);
            r    = $urandom_range(0, 9);
            if (r < 8)       addr = BASE + 32'($urandom_range(0, 31));
            else if (r == 8) addr = BASE - 32'($urandom_range(1, 64));
            else             addr = BASE + 32'd32 + 32'($urandom_range(0, 64));
            data = $urandom;
            if (is_store(op) && addr[4:2] == 3'd1 && $urandom_range(0, 9) != 0) begin
                op   = OP_SW;
                data = 32'($urandom_range(0, 6));
            end
            set_bus(op, addr, data, ena);
            check("rnd_hit1", {31'd0, hit1}, {31'd0, model_hit(ena, addr)});
            check("rnd_rd1", rd1, model_read(m1, op, ena, addr));
            check("rnd_irq1", {31'd0, irq1}, {31'd0, m1.expired & m1.ie});
            check("rnd_led1", {16'd0, led1}, {16'd0, m1.led});
            check("rnd_hit4", {31'd0, hit4}, {31'd0, model_hit(ena, addr)});
            check("rnd_rd4", rd4, model_read(m4, op, ena, addr));
            check("rnd_irq4", {31'd0, irq4}, {31'd0, m4.expired & m4.ie});
            check("rnd_led4", {16'd0, led4}, {16'd0, m4.led});
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_timer_responder.md
# mmio_timer_responder

Memory-mapped countdown timer and LED register that sits on the CPU data port beside DMEM and answers the same load/store protocol the CPU drives toward DMEM: enable, read/write strobes, per-size flags, and a raw byte address. It owns a 32-byte window at `BASE`, which is outside the DMEM range. Reads are combinational. Writes and timer updates happen on the rising clock edge. `sccomp_dataflow` ORs `hit` into its read-data mux to select `rd_data` over the DMEM output.

## Interface
- `BASE`, default 32'h10010400: window base address; bits [4:0] must be 0.
- `PRESCALE`, default 1: clock cycles per timer tick; legal range 1..65535.
- `clk_in` input 1: rising-edge clock, same clock as the CPU.
- `reset` input 1: asynchronous, active-high reset.
- `dm_ena` input 1: data access valid this cycle.
- `dm_r` input 1: read strobe.
- `dm_w` input 1: write strobe.
- `sb_flag`, `sh_flag`, `sw_flag` input 1 each: store size; one-hot when `dm_w` is asserted.
- `lb_flag`, `lh_flag`, `lbu_flag`, `lhu_flag`, `lw_flag` input 1 each: load size and signedness; one-hot when `dm_r` is asserted.
- `dm_addr` input 32: raw CPU byte address, before any DMEM conversion.
- `dm_data_w` input 32: store data; the byte or halfword is taken from the low bits.
- `hit` output 1: `dm_ena` is high and `dm_addr[31:5]` equals `BASE[31:5]`.
- `rd_data` output 32: load result, sign- or zero-extended.
- `irq` output 1: expired AND irq-enable.
- `led` output 16: LED register, bits [15:0].

## Operation
- Register map, selected by `dm_addr[4:2]`:
  - 0 CTRL: bit0 `en`, bit1 `reload`, bit2 `ie`; other bits read 0.
  - 1 LOAD: read/write.
  - 2 COUNT: read-only; writes are ignored.
  - 3 STATUS: bit0 `expired`; writing 1 clears it, writing 0 has no effect.
  - 4 LED: bits [15:0] read/write; upper bits read 0.
  - 5-7 are reserved: they read 0 and writes are ignored.
- Write path: acts only when `hit` and `dm_w` are both high.
  - `sw_flag`: all 4 byte lanes are written.
  - `sh_flag`: the lane pair selected by `dm_addr[1]` gets `dm_data_w[15:0]`.
  - `sb_flag`: the lane selected by `dm_addr[1:0]` gets `dm_data_w[7:0]`.
  - `dm_addr[0]` is ignored for halfword accesses.
- Side effect of writing LOAD: COUNT is loaded with the new LOAD value (after the byte merge) on the same edge.
- Read path: when `hit` and `dm_r` are both high, `rd_data` returns the addressed register, combinationally.
  - `lw`: the full word.
  - `lh`/`lhu`: the halfword selected by `dm_addr[1]`, sign- or zero-extended to 32 bits.
  - `lb`/`lbu`: the byte selected by `dm_addr[1:0]`, sign- or zero-extended to 32 bits.
  - Otherwise `rd_data` = 0.
- Prescaler: a 16-bit counter that runs only while `en` = 1. Each cycle it increments, and when it reaches `PRESCALE`-1 it wraps to 0 and emits `tick`. It is cleared when `en` = 0.
- Timer on a `tick`:
  - If COUNT != 0: COUNT decrements by 1.
  - If COUNT == 0: `expired` is set. If `reload` = 1, COUNT is loaded from LOAD. If `reload` = 0, `en` is cleared and COUNT holds at 0.
- Simultaneous events:
  - A CPU write to LOAD overrides the tick update of COUNT on the same edge.
  - Expiry setting `expired` wins over a STATUS write-1-to-clear on the same edge.
  - A CPU write to CTRL wins over the auto-clear of `en` on the same edge.
  - A reload with LOAD = 0 expires on every tick.

## Timing
- Reset, asynchronous, takes effect immediately: CTRL, LOAD, COUNT, STATUS, LED and the prescaler are all 0. Therefore `irq` = 0 and `led` = 0.
- Load latency is 0 cycles: `rd_data` and `hit` are combinational from the current inputs and register state.
- Store latency is 1 edge: the register value is visible to a read in the following cycle.
- `irq` is registered-derived. It rises in the cycle after the expiring tick edge and falls in the cycle after the clearing edge.
- With `PRESCALE` = 1, COUNT = N, and `en` set at edge 0:
  - COUNT reaches 0 after N edges.
  - `expired` sets at edge N+1.
- A reset in mid-count returns the block to its reset state; no partial update survives.

## Test plan
- Reset in mid-count: reset asserted at an arbitrary time → COUNT, STATUS, `irq` and `led` read 0 in the same cycle, and stay 0 after release.
- One-shot, `PRESCALE` = 1: `sw` 5 to LOAD, then `sw` 0x5 to CTRL (en, ie) → COUNT reads 4, 3, ... 0; `expired` and `irq` = 1 at edge 6; CTRL reads 0x4; COUNT holds at 0.
- Auto-reload with `PRESCALE` = 4: LOAD = 2, CTRL = 0x3 → `expired` sets every 12 cycles. A write-1-to-clear to STATUS on the expiry edge leaves `expired` = 1.
- Byte lanes on LED: `sw` 0; then `sb` 0xAB at offset 0x11; then `sh` 0x1234 at offset 0x12 → `led` = 0xAB00. `lw` reads 0x0000AB00, `lb` at 0x11 reads 0xFFFFFFAB, `lbu` at 0x11 reads 0x000000AB.
- LOAD halfword write: `sh` 0x8001 at LOAD offset 0x6 → LOAD = 0x80010000, COUNT = 0x80010000; `lh` at 0x6 reads 0xFFFF8001.
- Decode: accesses at `BASE`-4, at `BASE`+0x20, and with `dm_ena` = 0 → `hit` = 0, `rd_data` = 0, no register changes. Reserved offset 0x18 → `hit` = 1, reads 0, writes ignored.
